// File: rtl/pwm_mode_switch.sv
// Auto/manual PWM selector between an RC receiver and an MCU PWM generator.
//
// Auto mode is requested from the decoded width of the enable channel. Entry
// uses threshold hysteresis and needs CONFIRM consecutive qualifying strobes.
// Exit needs a single low sample. If pw_valid stops arriving, a loss-of-signal
// timeout fires. Each output line changes source only while both of its
// sources are low, so a pulse is never cut short or merged with another.
//
// Optional build macro: PWM_SWITCH_FAILSAFE_AUTO_EN
//   defined   - loss-of-signal forces AUTO (the MCU takes over)
//   undefined - loss-of-signal forces MANUAL (the receiver keeps control)
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   rcv_chan     receiver PWM lines            [NUM_CH]
//   mcu_chan     MCU PWM lines                 [NUM_CH]
//   pulwid_en    decoded enable-channel width  [PW_W]
//   pulwid_alter decoded alter-channel width   [PW_W]
//   pw_valid     one-cycle strobe, both widths new this cycle
//   chan         switched PWM outputs          [NUM_CH]
//   trigger      1 = auto mode requested (registered)
//   alter        registered alter decision
//   sel_done     every channel select equals trigger
//   sig_lost     loss-of-signal flag
module pwm_mode_switch #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned PW_W        = 8,
    parameter int unsigned EN_THRESH   = 150,
    parameter int unsigned HYST        = 10,
    parameter int unsigned CONFIRM     = 5,
    parameter int unsigned ALT_THRESH  = 150,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] rcv_chan,
    input  logic [NUM_CH-1:0] mcu_chan,
    input  logic [PW_W-1:0]   pulwid_en,
    input  logic [PW_W-1:0]   pulwid_alter,
    input  logic              pw_valid,
    output logic [NUM_CH-1:0] chan,
    output logic              trigger,
    output logic              alter,
    output logic              sel_done,
    output logic              sig_lost
);

    localparam int unsigned ConfW = $clog2(CONFIRM + 1);
    localparam int unsigned ToW   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [PW_W-1:0]  EnThresh  = PW_W'(EN_THRESH);
    localparam logic [PW_W-1:0]  EnRelease = PW_W'(EN_THRESH - HYST);
    localparam logic [PW_W-1:0]  AltThresh = PW_W'(ALT_THRESH);
    localparam logic [ConfW-1:0] ConfMax   = ConfW'(CONFIRM);
    localparam logic [ToW-1:0]   ToMax     = ToW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {StManual, StArming, StAuto} state_e;

`ifdef PWM_SWITCH_FAILSAFE_AUTO_EN
    localparam state_e LossState = StAuto;
`else
    localparam state_e LossState = StManual;
`endif

    state_e             state_q, state_d;
    logic [ConfW-1:0]   conf_q, conf_d;
    logic [ToW-1:0]     to_q, to_d;
    logic               trigger_q, alter_q, alter_d, lost_q, lost_d;
    logic [NUM_CH-1:0]  sel_q;
    logic               en_hi, en_lo, loss;

    assign en_hi = (pulwid_en >= EnThresh);
    assign en_lo = (pulwid_en < EnRelease);

    always_comb begin
        state_d = state_q;
        conf_d  = conf_q;
        alter_d = alter_q;
        lost_d  = lost_q;

        // Saturating silence counter; any strobe clears it.
        if (pw_valid) begin
            to_d = '0;
        end else if (to_q != ToMax) begin
            to_d = to_q + ToW'(1);
        end else begin
            to_d = to_q;
        end
        // A strobe in the cycle the count would saturate wins over the timeout.
        loss = !pw_valid && (to_d == ToMax);

        if (pw_valid) begin
            lost_d  = 1'b0;
            alter_d = (pulwid_alter >= AltThresh);
            unique case (state_q)
                StManual: begin
                    if (en_hi) begin
                        if (CONFIRM == 1) begin
                            state_d = StAuto;
                            conf_d  = '0;
                        end else begin
                            state_d = StArming;
                            conf_d  = ConfW'(1);
                        end
                    end
                end
                StArming: begin
                    if (!en_hi) begin
                        state_d = StManual;
                        conf_d  = '0;
                    end else if (conf_q + ConfW'(1) == ConfMax) begin
                        state_d = StAuto;
                        conf_d  = '0;
                    end else begin
                        conf_d = conf_q + ConfW'(1);
                    end
                end
                StAuto: begin
                    if (en_lo) begin
                        state_d = StManual;
                    end
                end
                default: begin
                    state_d = StManual;
                    conf_d  = '0;
                end
            endcase
        end else if (loss) begin
            lost_d  = 1'b1;
            alter_d = 1'b0;
            conf_d  = '0;
            state_d = LossState;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StManual;
            conf_q    <= '0;
            to_q      <= '0;
            trigger_q <= 1'b0;
            alter_q   <= 1'b0;
            lost_q    <= 1'b0;
            sel_q     <= '0;
        end else begin
            state_q   <= state_d;
            conf_q    <= conf_d;
            to_q      <= to_d;
            trigger_q <= (state_d == StAuto);
            alter_q   <= alter_d;
            lost_q    <= lost_d;
            // A channel follows trigger only in a gap where both sources are low.
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (!rcv_chan[i] && !mcu_chan[i]) begin
                    sel_q[i] <= trigger_q;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            chan[i] = sel_q[i] ? mcu_chan[i] : rcv_chan[i];
        end
    end

    assign trigger  = trigger_q;
    assign alter    = alter_q;
    assign sig_lost = lost_q;
    assign sel_done = (sel_q == {NUM_CH{trigger_q}});

endmodule

// File: doc/pwm_mode_switch.md
Name: pwm_mode_switch

Overview:
- Parametrised successor to the 4-channel RC/MCU auto-manual selector; sits between the receiver pulse-width decoder, the MCU PWM generator and the servo/ESC outputs.
- Routes NUM_CH PWM lines from either the RC receiver (manual) or the MCU (auto).
- Mode is chosen from a decoded enable-channel pulse width, with threshold hysteresis, N-sample confirmation and loss-of-signal timeout.
- Each output line is handed over only while both of its sources are low, so no runt or merged pulses ever reach the actuators.

Parameters:
- NUM_CH, 4: number of switched PWM channels (1..16).
- PW_W, 8: width of decoded pulse-width inputs.
- EN_THRESH, 150: enable width at or above which auto is requested.
- HYST, 10: auto released when enable width < EN_THRESH-HYST; must be < EN_THRESH.
- CONFIRM, 5: consecutive qualifying pw_valid strobes required to enter auto (>=1).
- ALT_THRESH, 150: alter width at or above which alter is asserted.
- TIMEOUT_CYC, 1000000: clocks without pw_valid before loss-of-signal (20 ms at 50 MHz).

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous reset, active-high.
- rcv_chan, in, NUM_CH: receiver PWM lines.
- mcu_chan, in, NUM_CH: MCU PWM lines.
- pulwid_en, in, PW_W: decoded enable-channel width.
- pulwid_alter, in, PW_W: decoded alter-channel width.
- pw_valid, in, 1: one-cycle strobe; both widths are new this cycle.
- chan, out, NUM_CH: switched PWM outputs.
- trigger, out, 1: 1 = auto mode requested (registered).
- alter, out, 1: registered alter decision.
- sel_done, out, 1: all per-channel selects equal trigger.
- sig_lost, out, 1: loss-of-signal flag.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state updates on the posedge of clk.
- Reset values:
  - state=MANUAL, trigger=0, alter=0, sig_lost=0.
  - conf_cnt=0, to_cnt=0, sel[*]=0.
  - Outputs: chan=rcv_chan, sel_done=1.
- en_hi = pulwid_en >= EN_THRESH; en_lo = pulwid_en < EN_THRESH-HYST. Both are unsigned PW_W-bit compares. Widths strictly between the two bands are neutral.
- FSM states MANUAL, ARMING, AUTO; trigger=1 only in AUTO. Only pw_valid cycles are evaluated.
  - MANUAL: pw_valid&en_hi -> conf_cnt=1; go to AUTO if CONFIRM==1, else ARMING.
  - ARMING, pw_valid&en_hi: conf_cnt+1. When the count reaches CONFIRM -> AUTO and conf_cnt=0.
  - ARMING, pw_valid&!en_hi (neutral or low): -> MANUAL, conf_cnt=0.
  - AUTO: pw_valid&en_lo -> MANUAL immediately (single sample; manual reclaim is never delayed). Neutral or high samples hold AUTO.
- trigger is registered from the next state: it rises on the clock edge that accepts the CONFIRM-th strobe.
- Timeout:
  - to_cnt clears on pw_valid and otherwise increments, saturating at TIMEOUT_CYC.
  - When to_cnt reaches TIMEOUT_CYC: sig_lost=1, conf_cnt=0, and the state forces to the loss target (see Optional Feature).
  - The next pw_valid clears sig_lost; that strobe is evaluated normally in the same cycle.
  - pw_valid in the same cycle the count would reach TIMEOUT_CYC: the strobe wins and no loss is flagged.
- alter:
  - On pw_valid, alter <= (pulwid_alter >= ALT_THRESH); otherwise it holds.
  - On loss-of-signal, alter <= 0.
- Per-channel handover:
  - sel[i] <= trigger only in a cycle where rcv_chan[i]==0 && mcu_chan[i]==0; otherwise sel[i] holds.
  - chan[i] = sel[i] ? mcu_chan[i] : rcv_chan[i], combinational from the registered sel.
  - If trigger toggles back before a channel switches, that sel[i] never changes.
- sel_done = (sel == {NUM_CH{trigger}}).
- Reset asserted mid-operation: all state, including sel, returns to reset values on the next edge, so outputs fall back to receiver immediately (the safe path takes priority over glitch-freedom under reset).
- Inputs are assumed already synchronised to clk.

Optional Feature:
- Macro PWM_SWITCH_FAILSAFE_AUTO_EN.
- Defined: loss-of-signal forces state to AUTO (trigger=1; the MCU autopilot takes over). A later pw_valid&en_lo returns to MANUAL as normal.
- Undefined: loss-of-signal forces state to MANUAL (trigger=0).
- sig_lost, alter clear and the handover rules are identical in both builds.

Test Plan:
- Reset, rcv_chan=4'b1010, mcu_chan=4'b0101 -> chan=4'b1010, trigger=0, sel_done=1, alter=0.
- Five pw_valid strobes with pulwid_en=160, then both sources held low -> trigger rises after the 5th strobe; chan follows mcu_chan; sel_done=1.
- Arm sequence of 160,160,145(neutral),160,160,160,160,160 -> the neutral sample resets ARMING; trigger rises only on the 8th strobe.
- In AUTO: pulwid_en=145 -> trigger stays 1; then 139 -> trigger=0 the next cycle.
- Handover glitch check: trigger rises while rcv_chan[2]=1, mcu_chan[2]=0 -> chan[2] stays 1 until rcv_chan[2] falls; sel[2] switches on the first both-low cycle; no output pulse is shorter than either source pulse.
- Stop pw_valid for TIMEOUT_CYC (bench override 100) while in MANUAL with alter=1 -> sig_lost=1, alter=0, trigger=0 (trigger=1 with PWM_SWITCH_FAILSAFE_AUTO_EN); the next pw_valid with en=100 clears sig_lost.
